// File: rtl/pe_row_sequencer_if.sv
// pe_row_sequencer_if
//   Handshake bundle between the PE row sequencer, the window-pixel source
//   and the score consumer.
//   Signals:
//     win_valid    source -> sequencer : window pixel available
//     win_ready    sequencer -> source : pixel accepted this cycle
//     result       sequencer -> sink   : captured score (ACC_W bits)
//     result_valid sequencer -> sink   : result held and valid
//     result_ready sink -> sequencer   : consumer accepts the result
//   Modports: master = sequencer side, slave = source/consumer side.
interface pe_row_sequencer_if #(
  parameter int ACC_W = 8
);
  logic             win_valid;
  logic             win_ready;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    input  win_valid,
    input  result_ready,
    output win_ready,
    output result,
    output result_valid
  );

  modport slave (
    output win_valid,
    output result_ready,
    input  win_ready,
    input  result,
    input  result_valid
  );
endinterface

// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer
//   Control FSM for one template-match pass over a row of NUM_PE chained
//   processing elements: load descriptor, stream WIN_LEN window pixels,
//   drain the accumulator chain for NUM_PE cycles, then present the score.
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     start, abort         begin a pass (IDLE only) / return to IDLE
//     bus (master)         win_valid/win_ready and result/result_valid/
//                          result_ready handshakes
//     load_desc/win/acc    strobes to every PE in the row
//     acc_in               accumulator output of the last PE
//     busy                 high in every state except IDLE
//     pass_cnt             completed (accepted) passes, wraps
//   Optional feature (macro SAD_THRESH_EN): adds thresh input, registered
//   match flag (acc_in <= thresh) and match_cnt of accepted matching results.
module pe_row_sequencer #(
  parameter int NUM_PE  = 4,
  parameter int WIN_LEN = 64,
  parameter int ACC_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  pe_row_sequencer_if.master bus,
  output logic             load_desc,
  output logic             load_win,
  output logic             load_acc,
  input  logic [ACC_W-1:0] acc_in,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt
`ifdef SAD_THRESH_EN
  ,
  input  logic [ACC_W-1:0] thresh,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int PIX_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int DRAIN_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(WIN_LEN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

  state_t state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [ACC_W-1:0]   result_q;
  logic               win_ready_c;
  logic               result_valid_c;
  logic               xfer;

  assign bus.win_ready    = win_ready_c;
  assign bus.result_valid = result_valid_c;
  assign bus.result       = result_q;
  assign busy             = (state_q != IDLE);
  assign xfer             = bus.win_valid && win_ready_c;

  // Next-state and strobe decode. abort overrides every transition,
  // including a result acceptance in the same cycle.
  always_comb begin
    state_d        = state_q;
    load_desc      = 1'b0;
    load_win       = 1'b0;
    load_acc       = 1'b0;
    win_ready_c    = 1'b0;
    result_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load_desc = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        win_ready_c = 1'b1;
        load_win    = bus.win_valid;
        load_acc    = bus.win_valid;
        if (bus.win_valid && (pix_cnt_q == PIX_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        load_acc = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) state_d = RESULT;
      end
      RESULT: begin
        result_valid_c = 1'b1;
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // State, counters and the captured score. The score is taken from the
  // last PE on the final drain cycle, when the chain has fully shifted out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      result_q    <= '0;
      pass_cnt    <= '0;
`ifdef SAD_THRESH_EN
      match       <= 1'b0;
      match_cnt   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (abort) begin
        pix_cnt_q   <= '0;
        drain_cnt_q <= '0;
      end else begin
        case (state_q)
          LOAD: begin
            pix_cnt_q   <= '0;
            drain_cnt_q <= '0;
          end
          STREAM: begin
            if (xfer) pix_cnt_q <= pix_cnt_q + 1'b1;
          end
          DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
              drain_cnt_q <= '0;
              result_q    <= acc_in;
`ifdef SAD_THRESH_EN
              match       <= (acc_in <= thresh);
`endif
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
          RESULT: begin
            if (bus.result_ready) begin
              pass_cnt <= pass_cnt + 1'b1;
`ifdef SAD_THRESH_EN
              if (match) match_cnt <= match_cnt + 1'b1;
`endif
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// tb_pe_row_sequencer
//   Directed self-checking bench for pe_row_sequencer with NUM_PE=4,
//   WIN_LEN=8 and a 3-bit pass counter so the wrap can be reached quickly.
//   Inputs change 1 time unit after the rising edge; outputs are compared
//   1-2 time units after the edge.
module tb_pe_row_sequencer;
  localparam int NUM_PE  = 4;
  localparam int WIN_LEN = 8;
  localparam int ACC_W   = 8;
  localparam int CNT_W   = 3;
  localparam int LAT     = 1 + WIN_LEN + NUM_PE + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [ACC_W-1:0] acc_in = '0;
  logic             load_desc, load_win, load_acc, busy;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] exp_pass = '0;
  int               checks = 0;
  int               errors = 0;

  pe_row_sequencer_if #(.ACC_W(ACC_W)) bus ();

`ifdef SAD_THRESH_EN
  logic [ACC_W-1:0] thresh = 8'd40;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] exp_match = '0;
`endif

  pe_row_sequencer #(
    .NUM_PE (NUM_PE),
    .WIN_LEN(WIN_LEN),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bus      (bus.master),
    .load_desc(load_desc),
    .load_win (load_win),
    .load_acc (load_acc),
    .acc_in   (acc_in),
    .busy     (busy),
    .pass_cnt (pass_cnt)
`ifdef SAD_THRESH_EN
    ,
    .thresh   (thresh),
    .match    (match),
    .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values before and just after the first release of rst.
  task automatic test_reset();
    #2;
    checks++;
    if ({busy, load_desc, load_win, load_acc, bus.win_ready, bus.result_valid} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b want 000000",
               {busy, load_desc, load_win, load_acc, bus.win_ready, bus.result_valid});
    end
    checks++;
    if (bus.result !== 8'd0 || pass_cnt !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs got result=%0d pass=%0d want 0 0", bus.result, pass_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  // Full pass with win_valid held high: strobe timeline checked every cycle.
  task automatic test_full_pass(input logic [ACC_W-1:0] acc_val);
    logic [3:0] exp_v, got_v;
    acc_in        = acc_val;
    bus.win_valid = 1'b1;
    start         = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      step();
      start = 1'b0;
      exp_v = {(i == 1), (i >= 2 && i <= WIN_LEN + 1),
               (i >= 2 && i <= WIN_LEN + NUM_PE + 1), (i == LAT)};
      got_v = {load_desc, load_win, load_acc, bus.result_valid};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL pass_cycle%0d desc/win/acc/rv got %b want %b", i, got_v, exp_v);
      end
    end
    checks++;
    if (bus.result !== acc_val) begin
      errors++;
      $display("[TB] FAIL pass_result got %0d want %0d", bus.result, acc_val);
    end
`ifdef SAD_THRESH_EN
    checks++;
    if (match !== (acc_val <= thresh)) begin
      errors++;
      $display("[TB] FAIL pass_match got %b want %b", match, (acc_val <= thresh));
    end
    if (acc_val <= thresh) exp_match++;
`endif
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    exp_pass++;
    checks++;
    if (pass_cnt !== exp_pass || bus.result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_accept got pass=%0d rv=%b busy=%b want %0d 0 0",
               pass_cnt, bus.result_valid, busy, exp_pass);
    end
`ifdef SAD_THRESH_EN
    checks++;
    if (match_cnt !== exp_match) begin
      errors++;
      $display("[TB] FAIL pass_match_cnt got %0d want %0d", match_cnt, exp_match);
    end
`endif
  endtask

  // win_valid toggling 1,0,1,0: only real transfers strobe, drain after the 8th.
  task automatic test_bubbles();
    int   xfers = 0;
    int   cyc   = 0;
    logic tog   = 1'b1;
    acc_in        = 8'd55;
    bus.win_valid = 1'b0;
    start         = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (load_desc !== 1'b1 || load_win !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bubble_load got desc=%b win=%b want 1 0", load_desc, load_win);
    end
    while (xfers < WIN_LEN && cyc < 40) begin
      step();
      cyc++;
      bus.win_valid = tog;
      #1;
      checks++;
      if ({bus.win_ready, load_win, load_acc, load_desc} !== {1'b1, tog, tog, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bubble_stream%0d rdy/win/acc/desc got %b want %b", cyc,
                 {bus.win_ready, load_win, load_acc, load_desc}, {1'b1, tog, tog, 1'b0});
      end
      if (tog) xfers++;
      tog = ~tog;
    end
    checks++;
    if (xfers != WIN_LEN) begin
      errors++;
      $display("[TB] FAIL bubble_xfers got %0d want %0d", xfers, WIN_LEN);
    end
    bus.win_valid = 1'b1;
    for (int d = 0; d < NUM_PE; d++) begin
      step();
      checks++;
      if ({load_acc, load_win, bus.win_ready} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL bubble_drain%0d acc/win/rdy got %b want 100", d,
                 {load_acc, load_win, bus.win_ready});
      end
    end
    step();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result !== 8'd55) begin
      errors++;
      $display("[TB] FAIL bubble_result got rv=%b res=%0d want 1 55", bus.result_valid, bus.result);
    end
`ifdef SAD_THRESH_EN
    if (8'd55 <= thresh) exp_match++;
`endif
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    exp_pass++;
    checks++;
    if (pass_cnt !== exp_pass) begin
      errors++;
      $display("[TB] FAIL bubble_pass got %0d want %0d", pass_cnt, exp_pass);
    end
  endtask

  // Abort on the 3rd transfer, then a clean full pass.
  task automatic test_abort();
    bus.win_valid = 1'b1;
    start         = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    #1;
    checks++;
    if (load_win !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_third_xfer load_win got %b want 1", load_win);
    end
    step();
    abort = 1'b0;
    checks++;
    if ({busy, load_desc, load_win, load_acc, bus.win_ready} !== 5'b0 || pass_cnt !== exp_pass) begin
      errors++;
      $display("[TB] FAIL abort_idle got flags=%b pass=%0d want 00000 %0d",
               {busy, load_desc, load_win, load_acc, bus.win_ready}, pass_cnt, exp_pass);
    end
    test_full_pass(8'd37);
  endtask

  task automatic run_to_result(input logic [ACC_W-1:0] acc_val);
    int cyc = 0;
    acc_in        = acc_val;
    bus.win_valid = 1'b1;
    start         = 1'b1;
    step();
    start = 1'b0;
    while (bus.result_valid !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL result_timeout rv got %b want 1", bus.result_valid);
    end
  endtask

  // abort together with result_ready: back to IDLE, acceptance not counted.
  task automatic test_abort_result();
    run_to_result(8'd12);
    bus.result_ready = 1'b1;
    abort            = 1'b1;
    step();
    bus.result_ready = 1'b0;
    abort            = 1'b0;
    checks++;
    if (busy !== 1'b0 || pass_cnt !== exp_pass || bus.result !== 8'd12) begin
      errors++;
      $display("[TB] FAIL abort_result got busy=%b pass=%0d res=%0d want 0 %0d 12",
               busy, pass_cnt, bus.result, exp_pass);
    end
  endtask

  // Consumer stalls 5 cycles; start pulses during RESULT are ignored.
  task automatic test_hold();
    run_to_result(8'd99);
    acc_in = 8'd3;
    for (int h = 0; h < 5; h++) begin
      start = (h == 1 || h == 3);
      step();
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== 8'd99 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold%0d got rv=%b res=%0d busy=%b want 1 99 1", h,
                 bus.result_valid, bus.result, busy);
      end
    end
    start            = 1'b0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    exp_pass++;
    checks++;
    if (pass_cnt !== exp_pass || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_accept got pass=%0d busy=%b want %0d 0", pass_cnt, busy, exp_pass);
    end
    step();
    checks++;
    if (busy !== 1'b0 || pass_cnt !== exp_pass) begin
      errors++;
      $display("[TB] FAIL hold_no_queue got busy=%b pass=%0d want 0 %0d", busy, pass_cnt, exp_pass);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_desc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_abort_idle got busy=%b desc=%b want 0 0", busy, load_desc);
    end
  endtask

  // Asynchronous reset between edges while draining.
  task automatic test_reset_mid_drain();
    bus.win_valid = 1'b1;
    acc_in        = 8'd77;
    start         = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIN_LEN + 2; i++) step();
    checks++;
    if (load_acc !== 1'b1 || load_win !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_pre_drain got acc=%b win=%b want 1 0", load_acc, load_win);
    end
    #2;
    rst = 1'b0;
    #1;
    exp_pass = '0;
    checks++;
    if ({busy, load_desc, load_win, load_acc, bus.win_ready, bus.result_valid} !== 6'b0 ||
        bus.result !== 8'd0 || pass_cnt !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_async got flags=%b res=%0d pass=%0d want 000000 0 0",
               {busy, load_desc, load_win, load_acc, bus.win_ready, bus.result_valid},
               bus.result, pass_cnt);
    end
`ifdef SAD_THRESH_EN
    exp_match = '0;
    checks++;
    if (match !== 1'b0 || match_cnt !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_match got match=%b cnt=%0d want 0 0", match, match_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || load_acc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release got busy=%b acc=%b want 0 0", busy, load_acc);
    end
  endtask

  // Eight accepted passes on a 3-bit counter: 7 -> 0.
  task automatic test_wrap();
    for (int p = 0; p < 8; p++) test_full_pass(8'(p + 50));
    checks++;
    if (pass_cnt !== 3'd0) begin
      errors++;
      $display("[TB] FAIL wrap got %0d want 0", pass_cnt);
    end
  endtask

  initial begin
    bus.win_valid    = 1'b0;
    bus.result_ready = 1'b0;
    test_reset();
    test_full_pass(8'd37);
    test_bubbles();
    test_abort();
    test_abort_result();
    test_hold();
    test_start_abort_idle();
`ifdef SAD_THRESH_EN
    test_full_pass(8'd37);
    test_full_pass(8'd41);
`endif
    test_reset_mid_drain();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
